// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Shadows rd/regwrite through EX, MEM and WB so the core only supplies ID-stage decode fields.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] FwdNone = 2'b00;
  localparam logic [1:0] FwdWb   = 2'b01;
  localparam logic [1:0] FwdMem  = 2'b10;

  logic [REG_W-1:0] exRs1_q, exRs1_d;
  logic [REG_W-1:0] exRs2_q, exRs2_d;
  logic [REG_W-1:0] exRd_q, exRd_d;
  logic             exRegWrite_q, exRegWrite_d;
  logic             exMemRead_q, exMemRead_d;
  logic [REG_W-1:0] memRd_q, memRd_d;
  logic             memRegWrite_q, memRegWrite_d;
  logic [REG_W-1:0] wbRd_q, wbRd_d;
  logic             wbRegWrite_q, wbRegWrite_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic loadUse;
  logic insertBubble;

  // The newest producer wins, and x0 is never a forwarding source.
  function automatic logic [1:0] selectSource(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] memRd,
    input logic             memRegWrite,
    input logic [REG_W-1:0] wbRd,
    input logic             wbRegWrite
  );
    logic [1:0] sel;
    sel = FwdNone;
    if (memRegWrite && (memRd != '0) && (memRd == src)) begin
      sel = FwdMem;
    end else if (wbRegWrite && (wbRd != '0) && (wbRd == src)) begin
      sel = FwdWb;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_o = selectSource(exRs1_q, memRd_q, memRegWrite_q, wbRd_q, wbRegWrite_q);
    fwd_b_o = selectSource(exRs2_q, memRd_q, memRegWrite_q, wbRd_q, wbRegWrite_q);
  end

  // A taken branch squashes the consumer, so flush suppresses the stall.
  always_comb begin
    loadUse = exMemRead_q && (exRd_q != '0) &&
              ((exRd_q == id_rs1_i) || (exRd_q == id_rs2_i));
    stall_o      = loadUse && !flush_i;
    insertBubble = stall_o || flush_i;
    pc_write_o   = !stall_o;
    ifid_write_o = !stall_o;
  end

  always_comb begin
    wbRd_d        = memRd_q;
    wbRegWrite_d  = memRegWrite_q;
    memRd_d       = exRd_q;
    memRegWrite_d = exRegWrite_q;
    if (insertBubble) begin
      exRs1_d      = '0;
      exRs2_d      = '0;
      exRd_d       = '0;
      exRegWrite_d = 1'b0;
      exMemRead_d  = 1'b0;
    end else begin
      exRs1_d      = id_rs1_i;
      exRs2_d      = id_rs2_i;
      exRd_d       = id_rd_i;
      exRegWrite_d = id_regwrite_i;
      exMemRead_d  = id_memread_i;
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stall_o && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stallCnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      exRs1_q       <= '0;
      exRs2_q       <= '0;
      exRd_q        <= '0;
      exRegWrite_q  <= 1'b0;
      exMemRead_q   <= 1'b0;
      memRd_q       <= '0;
      memRegWrite_q <= 1'b0;
      wbRd_q        <= '0;
      wbRegWrite_q  <= 1'b0;
      stallCnt_q    <= '0;
    end else begin
      exRs1_q       <= exRs1_d;
      exRs2_q       <= exRs2_d;
      exRd_q        <= exRd_d;
      exRegWrite_q  <= exRegWrite_d;
      exMemRead_q   <= exMemRead_d;
      memRd_q       <= memRd_d;
      memRegWrite_q <= memRegWrite_d;
      wbRd_q        <= wbRd_d;
      wbRegWrite_q  <= wbRegWrite_d;
      stallCnt_q    <= stallCnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, hand sequences for reset and saturation,
// then random instruction streams against a pipeline-history reference model.
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct {
    string      name;
    instr_t     ins;
    logic       flush;
    logic [1:0] expA;
    logic [1:0] expB;
    logic       expStall;
    int         expCnt;
  } vec_t;

  logic        clk;
  logic        rst_i;
  logic [4:0]  idRs1, idRs2, idRd;
  logic        idRegWrite, idMemRead, flush;
  logic [1:0]  fwdA, fwdB, fwdASat, fwdBSat;
  logic        stall, pcWrite, ifidWrite;
  logic        stallSat, pcWriteSat, ifidWriteSat;
  logic [15:0] stallCnt;
  logic [1:0]  stallCntSat;

  int vectors;
  int miscompares;

  // Reference model: the three most recent instructions to have entered EX, newest first.
  instr_t pipe [3];
  int     modelCnt;

  fwd_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs1_i(idRs1), .id_rs2_i(idRs2), .id_rd_i(idRd),
    .id_regwrite_i(idRegWrite), .id_memread_i(idMemRead), .flush_i(flush),
    .fwd_a_o(fwdA), .fwd_b_o(fwdB), .stall_o(stall),
    .pc_write_o(pcWrite), .ifid_write_o(ifidWrite), .stall_cnt_o(stallCnt)
  );

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dutSat (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs1_i(idRs1), .id_rs2_i(idRs2), .id_rd_i(idRd),
    .id_regwrite_i(idRegWrite), .id_memread_i(idMemRead), .flush_i(flush),
    .fwd_a_o(fwdASat), .fwd_b_o(fwdBSat), .stall_o(stallSat),
    .pc_write_o(pcWriteSat), .ifid_write_o(ifidWriteSat), .stall_cnt_o(stallCntSat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mkIns(int rs1, int rs2, int rd, int rw, int mr);
    instr_t i;
    i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd);
    i.rw = (rw != 0); i.mr = (mr != 0);
    return i;
  endfunction

  function automatic vec_t mk(string n, instr_t ins, int fl, int eA, int eB, int eS, int eC);
    vec_t v;
    v.name = n; v.ins = ins; v.flush = (fl != 0);
    v.expA = 2'(eA); v.expB = 2'(eB); v.expStall = (eS != 0); v.expCnt = eC;
    return v;
  endfunction

  function automatic logic [1:0] modelFwd(logic [4:0] src);
    for (int s = 1; s <= 2; s++) begin
      if (pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == src) return (s == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic modelStall(instr_t id, logic fl);
    return pipe[0].mr && pipe[0].rd != 0 && (pipe[0].rd == id.rs1 || pipe[0].rd == id.rs2) && !fl;
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    modelCnt = 0;
  endtask

  task automatic modelAdvance(instr_t id, logic fl);
    logic st;
    st = modelStall(id, fl);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (st || fl) ? '0 : id;
    if (st) modelCnt++;
  endtask

  task automatic applyStimulus(instr_t ins, logic fl);
    idRs1 = ins.rs1; idRs2 = ins.rs2; idRd = ins.rd;
    idRegWrite = ins.rw; idMemRead = ins.mr; flush = fl;
  endtask

  task automatic checkValue(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic checkOutput(string name, logic [1:0] eA, logic [1:0] eB, logic eS, int eC);
    int satCnt;
    satCnt = (eC > 3) ? 3 : eC;
    vectors++;
    if (fwdA !== eA || fwdB !== eB || stall !== eS || pcWrite !== !eS || ifidWrite !== !eS ||
        stallCnt !== 16'(eC) || stallCntSat !== 2'(satCnt) || fwdASat !== eA || fwdBSat !== eB ||
        stallSat !== eS) begin
      miscompares++;
      $display("[TB] FAIL %s: got a=%b b=%b stall=%b pcw=%b ifidw=%b cnt=%0d cnt2=%0d, expected a=%b b=%b stall=%b cnt=%0d cnt2=%0d",
               name, fwdA, fwdB, stall, pcWrite, ifidWrite, stallCnt, stallCntSat,
               eA, eB, eS, eC, satCnt);
    end
  endtask

  // One cycle driven from a negedge: expectations come from the model, then the model advances.
  task automatic stepModel(instr_t ins, logic fl, string name, output logic st);
    applyStimulus(ins, fl);
    #1;
    st = modelStall(ins, fl);
    checkOutput(name, modelFwd(pipe[0].rs1), modelFwd(pipe[0].rs2), st, modelCnt);
    @(posedge clk);
    modelAdvance(ins, fl);
    @(negedge clk);
  endtask

  vec_t tbl [25];

  initial begin
    instr_t nop, cur, lw8, add8;
    logic   st, fl;

    vectors = 0; miscompares = 0;
    nop  = '0;
    lw8  = mkIns(2, 0, 8, 1, 1);
    add8 = mkIns(3, 8, 13, 1, 0);

    tbl[0]  = mk("exmem_producer", mkIns(1, 2, 5, 1, 0), 0, 0, 0, 0, 0);
    tbl[1]  = mk("exmem_consumer", mkIns(5, 5, 9, 1, 0), 0, 0, 0, 0, 0);
    tbl[2]  = mk("exmem_fwd",      nop,                  0, 2, 2, 0, 0);
    tbl[3]  = mk("exmem_after",    nop,                  0, 0, 0, 0, 0);
    tbl[4]  = mk("memwb_producer", mkIns(0, 0, 6, 1, 0), 0, 0, 0, 0, 0);
    tbl[5]  = mk("memwb_gap",      nop,                  0, 0, 0, 0, 0);
    tbl[6]  = mk("memwb_consumer", mkIns(6, 0, 10, 1, 0), 0, 0, 0, 0, 0);
    tbl[7]  = mk("memwb_fwd",      nop,                  0, 1, 0, 0, 0);
    tbl[8]  = mk("prio_first",     mkIns(1, 2, 7, 1, 0), 0, 0, 0, 0, 0);
    tbl[9]  = mk("prio_second",    mkIns(3, 4, 7, 1, 0), 0, 0, 0, 0, 0);
    tbl[10] = mk("prio_consumer",  mkIns(7, 0, 11, 1, 0), 0, 0, 0, 0, 0);
    tbl[11] = mk("prio_newest",    nop,                  0, 2, 0, 0, 0);
    tbl[12] = mk("x0_producer",    mkIns(1, 0, 0, 1, 0), 0, 0, 0, 0, 0);
    tbl[13] = mk("x0_consumer",    mkIns(0, 0, 12, 1, 0), 0, 0, 0, 0, 0);
    tbl[14] = mk("x0_no_fwd",      nop,                  0, 0, 0, 0, 0);
    tbl[15] = mk("x0_load",        mkIns(1, 0, 0, 1, 1), 0, 0, 0, 0, 0);
    tbl[16] = mk("x0_no_stall",    mkIns(0, 0, 12, 1, 0), 0, 0, 0, 0, 0);
    tbl[17] = mk("lu_load",        lw8,                  0, 0, 0, 0, 0);
    tbl[18] = mk("lu_stall",       add8,                 0, 0, 0, 1, 0);
    tbl[19] = mk("lu_held",        add8,                 0, 0, 0, 0, 1);
    tbl[20] = mk("lu_wb_fwd",      nop,                  0, 0, 1, 0, 1);
    tbl[21] = mk("fl_load",        mkIns(1, 0, 9, 1, 1), 0, 0, 0, 0, 1);
    tbl[22] = mk("fl_flush",       mkIns(9, 0, 14, 1, 0), 1, 0, 0, 0, 1);
    tbl[23] = mk("fl_bubble",      nop,                  0, 0, 0, 0, 1);
    tbl[24] = mk("fl_after",       nop,                  0, 0, 0, 0, 1);

    rst_i = 1'b0;
    applyStimulus(nop, 1'b0);
    modelReset();
    #1;
    checkOutput("reset", 2'b00, 2'b00, 1'b0, 0);
    @(negedge clk);
    rst_i = 1'b1;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(tbl[i].ins, tbl[i].flush);
      #1;
      checkOutput(tbl[i].name, tbl[i].expA, tbl[i].expB, tbl[i].expStall, tbl[i].expCnt);
      @(posedge clk);
      modelAdvance(tbl[i].ins, tbl[i].flush);
      @(negedge clk);
    end

    // Five load-use stalls: the 2-bit counter must pin at 3 while the wide one reaches 6.
    for (int k = 0; k < 5; k++) begin
      stepModel(lw8, 1'b0, "sat_load", st);
      stepModel(add8, 1'b0, "sat_stall", st);
      stepModel(add8, 1'b0, "sat_held", st);
    end
    checkValue("sat_cnt_wide", int'(stallCnt), 6);
    checkValue("sat_cnt_narrow", int'(stallCntSat), 3);

    // Asynchronous reset in the middle of a pending load-use stall.
    stepModel(lw8, 1'b0, "rst_load", st);
    applyStimulus(add8, 1'b0);
    #1;
    checkOutput("rst_pending", modelFwd(pipe[0].rs1), modelFwd(pipe[0].rs2), 1'b1, modelCnt);
    #2;
    rst_i = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_mid_stall", 2'b00, 2'b00, 1'b0, 0);
    @(negedge clk);
    rst_i = 1'b1;

    st = 1'b0;
    cur = nop;
    for (int n = 0; n < 400; n++) begin
      if (!st) begin
        cur = mkIns($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
      fl = ($urandom_range(0, 7) == 0);
      stepModel(cur, fl, "random", st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline. It produces the 2-bit forward-select codes that drive the EX-stage operand multiplexers, and the stall and bubble controls for the front end. It tracks register-destination information through EX, MEM and WB in its own shadow pipeline registers, so the core only supplies ID-stage decode fields. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and advances with them.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, stall-counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- id_rs1_i  in  REG_W  rs1 index of the instruction in ID
- id_rs2_i  in  REG_W  rs2 index of the instruction in ID
- id_rd_i  in  REG_W  rd index of the instruction in ID
- id_regwrite_i  in  1  instruction in ID writes rd
- id_memread_i  in  1  instruction in ID is a load
- flush_i  in  1  squash the instruction in ID (taken branch)
- fwd_a_o  out  2  EX operand A select
- fwd_b_o  out  2  EX operand B select
- stall_o  out  1  load-use stall: hold PC and IF/ID, bubble into ID/EX
- pc_write_o  out  1  ~stall_o
- ifid_write_o  out  1  ~stall_o
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Shadow stages:
  - EX: rs1, rs2, rd, regwrite, memread
  - MEM: rd, regwrite
  - WB: rd, regwrite
- Each rising edge:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields, or a bubble (all fields zero) when stall_o=1 or flush_i=1.
- Forward-select encoding matches the operand mux:
  - 00: register-file / ID/EX value.
  - 01: MEM/WB writeback value.
  - 10: EX/MEM ALU result.
  - 11 is never driven.
- fwd_a_o, computed combinationally from registered state only:
  - 10 if MEM.regwrite && MEM.rd!=0 && MEM.rd==EX.rs1.
  - else 01 if WB.regwrite && WB.rd!=0 && WB.rd==EX.rs1.
  - else 00.
- fwd_b_o: same rules using EX.rs2.
- EX/MEM has priority over MEM/WB when both match (newest value wins).
- Register x0 is never forwarded, regardless of regwrite.
- stall_o = EX.memread && EX.rd!=0 && (EX.rd==id_rs1_i || EX.rd==id_rs2_i) && !flush_i.
  - Stall is combinational from the ID inputs.
  - Exactly one bubble is inserted per load-use. The following cycle the load is in MEM, and forwarding supplies the operand via 01 one cycle later.
- Simultaneous flush_i and hazard: flush wins, stall_o=0, bubble inserted.
- stall_cnt_o increments on every rising edge where stall_o=1. It saturates at all-ones and does not wrap.

## Timing
- Reset (rst_i=0, asynchronous): all shadow fields are zero.
  - fwd_a_o=fwd_b_o=00, stall_o=0, pc_write_o=ifid_write_o=1, stall_cnt_o=0.
  - Outputs take these values immediately, with no clock required.
- Reset asserted mid-stall: stall_o drops at once. The counter keeps no residue.
- Reset release: first capture on the first rising edge with rst_i=1.
- Latency:
  - An ID-stage instruction reaches EX shadow 1 cycle later, MEM 2 cycles later, WB 3 cycles later.
  - Forward selects are valid in the same cycle the consumer is in EX.
  - stall_o is valid in the same cycle the consumer is in ID.
- Stalls are never longer than 1 consecutive cycle for a single load. Back-to-back loads each produce their own stall.
- The outputs depend only on registered state and the ID inputs. There is no combinational path from stall_o back to its own inputs.

## Test plan
- Reset: drive rst_i=0 asynchronously mid-cycle with a pending hazard.
  - Required: fwd_*=00, stall_o=0, stall_cnt_o=0 immediately.
- EX/MEM forward: "add x5" then "sub rs1=x5, rs2=x5".
  - Required: when the sub is in EX, fwd_a_o=fwd_b_o=10.
- MEM/WB forward and priority:
  - "add x6", "nop", then "or rs1=x6". Required: fwd_a_o=01.
  - "add x7", "add x7", "xor rs1=x7". Required: fwd_a_o=10 (newest wins).
- x0 guard: "addi x0" then "add rs1=x0, rs2=x0".
  - Required: fwd_a_o=fwd_b_o=00, stall_o=0.
- Load-use: "lw x8" then "add rs2=x8".
  - Required: stall_o=1 for exactly 1 cycle, with pc_write_o=ifid_write_o=0.
  - Required: a bubble enters EX, stall_cnt_o increments by 1.
  - Required: the add later sees fwd_b_o=01.
- Flush and saturation:
  - Load-use with flush_i=1 in the same cycle. Required: stall_o=0, bubble inserted.
  - With CNT_W=2, force 5 stall cycles. Required: stall_cnt_o holds at 3.
